// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic engine:
// controller state encoding and a width helper for counters.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a right and b down, and accumulates
// the extended product into a wrapping AW-bit accumulator.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          mode_signed,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] a_ext, b_ext, prod;

    // Operands are widened to AW before multiplying; the low AW bits of that
    // product equal the extended 2*DW product because AW >= 2*DW.
    always_comb begin
        a_ext = mode_signed ? {{(AW-DW){a_in[DW-1]}}, a_in} : {{(AW-DW){1'b0}}, a_in};
        b_ext = mode_signed ? {{(AW-DW){b_in[DW-1]}}, b_in} : {{(AW-DW){1'b0}}, b_in};
        prod  = a_ext * b_ext;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = (clr ? '0 : acc_q) + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary ROWSxCOLS systolic matmul: input skew lines, PE grid,
// and the IDLE/FEED/FLUSH/DRAIN controller that streams out result rows.
module systolic_array_os
    import systolic_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 24
) (
    input  logic                 CLOCK,
    input  logic                 reset_n,
    input  logic                 mode_signed,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [ROWS*DW-1:0]   a_vec,
    input  logic [COLS*DW-1:0]   b_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [COLS*AW-1:0]   out_data
);

    localparam int CW = clog2(ROWS + COLS);
    localparam int RW = clog2(ROWS);
    localparam logic [CW-1:0] FLUSH_INIT = CW'(ROWS + COLS - 2);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          mode_q, mode_d;
    logic          accept, flushing, en, clr, mode_eff;

    logic [DW-1:0] a_w [ROWS][COLS+1];
    logic [DW-1:0] b_w [ROWS+1][COLS];
    logic [AW-1:0] acc_w [ROWS][COLS];
    logic [DW-1:0] a_edge_unused [ROWS];
    logic [DW-1:0] b_edge_unused [COLS];

    assign accept   = in_valid && in_ready;
    assign flushing = (state_q == ST_FLUSH);
    assign en       = accept || flushing;
    assign clr      = accept && (state_q == ST_IDLE);
    // The first beat is multiplied on the same edge that latches the mode.
    assign mode_eff = (state_q == ST_IDLE) ? mode_signed : mode_q;

    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DW-1:0] lane;
        assign lane = flushing ? '0 : a_vec[i*DW +: DW];
        if (i == 0) begin : g_direct
            assign a_w[i][0] = lane;
        end else begin : g_dly
            logic [i-1:0][DW-1:0] sh_q, sh_d;
            always_comb begin
                sh_d = sh_q;
                if (en) begin
                    sh_d[0] = lane;
                    for (int k = 1; k < i; k++) sh_d[k] = sh_q[k-1];
                end
            end
            always_ff @(posedge CLOCK or negedge reset_n) begin
                if (!reset_n) sh_q <= '0;
                else          sh_q <= sh_d;
            end
            assign a_w[i][0] = sh_q[i-1];
        end
        assign a_edge_unused[i] = a_w[i][COLS];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic [DW-1:0] lane;
        assign lane = flushing ? '0 : b_vec[j*DW +: DW];
        if (j == 0) begin : g_direct
            assign b_w[0][j] = lane;
        end else begin : g_dly
            logic [j-1:0][DW-1:0] sh_q, sh_d;
            always_comb begin
                sh_d = sh_q;
                if (en) begin
                    sh_d[0] = lane;
                    for (int k = 1; k < j; k++) sh_d[k] = sh_q[k-1];
                end
            end
            always_ff @(posedge CLOCK or negedge reset_n) begin
                if (!reset_n) sh_q <= '0;
                else          sh_q <= sh_d;
            end
            assign b_w[0][j] = sh_q[j-1];
        end
        assign b_edge_unused[j] = b_w[ROWS][j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk         (CLOCK),
                .rst_n       (reset_n),
                .en          (en),
                .clr         (clr),
                .mode_signed (mode_eff),
                .a_in        (a_w[i][j]),
                .b_in        (b_w[i][j]),
                .a_out       (a_w[i][j+1]),
                .b_out       (b_w[i+1][j]),
                .acc         (acc_w[i][j])
            );
        end
    end

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                mode_d  = mode_signed;
                row_d   = '0;
                state_d = in_last ? ST_FLUSH : ST_FEED;
                cnt_d   = FLUSH_INIT;
            end
            ST_FEED: if (accept && in_last) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_INIT;
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_DRAIN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_DRAIN: if (out_ready) begin
                if (row_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || (state_q == ST_FEED);
        out_valid = (state_q == ST_DRAIN);
        out_last  = (state_q == ST_DRAIN) && (row_q == LAST_ROW);
        out_data  = '0;
        if (state_q == ST_DRAIN) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_q == RW'(r)) begin
                    for (int j = 0; j < COLS; j++) out_data[j*AW +: AW] = acc_w[r][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_os.sv
// Scoreboard bench for systolic_array_os (4x4, DW=8, AW=16): stimulus pushes
// expected rows, a negedge monitor pops and compares on each row handshake.
module tb_systolic_array_os;

    localparam int R    = 4;
    localparam int C    = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int KMAX = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode_signed;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [R*DW-1:0]  a_vec;
    logic [C*DW-1:0]  b_vec;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [C*AW-1:0]  out_data;

    typedef struct packed {
        logic [C*AW-1:0] data;
        logic            last;
    } exp_t;

    exp_t         exp_q[$];
    logic [DW-1:0] A [R][KMAX];
    logic [DW-1:0] B [KMAX][C];
    int           checks = 0;
    int           errors = 0;
    int           rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

    systolic_array_os #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW)) dut (
        .CLOCK       (clk),
        .reset_n     (rst_n),
        .mode_signed (mode_signed),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_row(input int c0, input int c1, input int c2, input int c3, input bit last);
        exp_t e;
        e.data = {AW'(c3), AW'(c2), AW'(c1), AW'(c0)};
        e.last = last;
        exp_q.push_back(e);
    endtask

    function automatic longint ext(input logic [DW-1:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    task automatic push_model(input int k, input bit sgn);
        exp_t   e;
        longint s;
        for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += ext(A[i][kk], sgn) * ext(B[kk][j], sgn);
                e.data[j*AW +: AW] = s[AW-1:0];
            end
            e.last = (i == R-1);
            exp_q.push_back(e);
        end
    endtask

    task automatic clr_mats();
        for (int i = 0; i < R; i++) for (int k = 0; k < KMAX; k++) A[i][k] = '0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < C; j++) B[k][j] = '0;
    endtask

    // Later beats and flush-time junk carry the opposite mode, which must be ignored.
    task automatic feed_tile(input int k, input bit sgn, input int gap_pct);
        int n;
        for (int kk = 0; kk < k; kk++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
                a_vec    = $urandom;
            end
            @(negedge clk);
            in_valid    = 1'b1;
            in_last     = (kk == k-1);
            mode_signed = (kk == 0) ? sgn : !sgn;
            for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = A[i][kk];
            for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = B[kk][j];
            chk("in_ready_feed", 64'(in_ready), 1);
            @(posedge clk);
        end
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (out_valid || n >= 40) break;
            chk("in_ready_flush", 64'(in_ready), 0);
            in_valid    = 1'b1;
            in_last     = 1'b1;
            mode_signed = !sgn;
            a_vec       = $urandom;
            b_vec       = $urandom;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("first_valid_latency", 64'(n), 64'(R + C));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(exp_q.size()), 0);
        @(negedge clk);
        chk("valid_low_after_drain", 64'(out_valid), 0);
    endtask

    task automatic load_2x2();
        clr_mats();
        A[0][0] = 8'd1; A[1][0] = 8'd3; B[0][0] = 8'd5; B[0][1] = 8'd6;
        A[0][1] = 8'd2; A[1][1] = 8'd4; B[1][0] = 8'd7; B[1][1] = 8'd8;
    endtask

    task automatic push_2x2();
        push_row(19, 22, 0, 0, 0);
        push_row(43, 50, 0, 0, 0);
        push_row(0, 0, 0, 0, 0);
        push_row(0, 0, 0, 0, 1);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares rows on handshake and checks stalled rows stay put.
    initial begin
        logic [C*AW-1:0] held;
        bit              holding;
        exp_t            e;
        holding = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 0;
            end else if (out_valid) begin
                if (holding) chk("row_stable", out_data, held);
                if (out_ready) begin
                    chk("row_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("row_data", out_data, e.data);
                        chk("row_last", 64'(out_last), 64'(e.last));
                    end
                    holding = 0;
                end else begin
                    held    = out_data;
                    holding = 1;
                end
            end else begin
                if (holding) chk("valid_dropped", 64'(out_valid), 1);
                holding = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        mode_signed = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        a_vec       = '0;
        b_vec       = '0;
        clr_mats();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 1);
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_out_last", 64'(out_last), 0);
        chk("reset_out_data", out_data, 0);

        // 2x2 hand-computed product in the upper-left corner.
        load_2x2();
        push_2x2();
        feed_tile(2, 1'b0, 0);
        wait_drain();

        // K=1 signed and unsigned of 0xFF * 0x02.
        clr_mats();
        A[0][0] = 8'hFF; B[0][0] = 8'h02;
        push_row(16'hFFFE, 0, 0, 0, 0); push_row(0, 0, 0, 0, 0);
        push_row(0, 0, 0, 0, 0);        push_row(0, 0, 0, 0, 1);
        feed_tile(1, 1'b1, 0);
        wait_drain();
        push_row(510, 0, 0, 0, 0); push_row(0, 0, 0, 0, 0);
        push_row(0, 0, 0, 0, 0);   push_row(0, 0, 0, 0, 1);
        feed_tile(1, 1'b0, 0);
        wait_drain();

        // Accumulator wrap: 2 * 255 * 255 = 130050 -> 64514 mod 2^16.
        clr_mats();
        A[0][0] = 8'hFF; A[0][1] = 8'hFF; B[0][0] = 8'hFF; B[1][0] = 8'hFF;
        push_row(64514, 0, 0, 0, 0); push_row(0, 0, 0, 0, 0);
        push_row(0, 0, 0, 0, 0);     push_row(0, 0, 0, 0, 1);
        feed_tile(2, 1'b0, 0);
        wait_drain();

        // Full 4x4, K=16, input gaps and random output backpressure.
        for (int i = 0; i < R; i++)
            for (int k = 0; k < KMAX; k++) A[i][k] = DW'(i*37 + k*53 + 91);
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < C; j++) B[k][j] = DW'(k*29 + j*71 + 140);
        rdy_mode = 2;
        push_model(KMAX, 1'b0);
        feed_tile(KMAX, 1'b0, 50);
        wait_drain();
        push_model(KMAX, 1'b1);
        feed_tile(KMAX, 1'b1, 50);
        wait_drain();

        // Reset while a drain is stalled, then a clean tile.
        rdy_mode = 1;
        load_2x2();
        @(negedge clk);
        feed_tile(2, 1'b0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("drain_stall_valid", 64'(out_valid), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_drain_valid", 64'(out_valid), 0);
        chk("rst_mid_drain_last", 64'(out_last), 0);
        chk("rst_mid_drain_data", out_data, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 1);
        chk("post_reset_out_valid", 64'(out_valid), 0);
        push_2x2();
        feed_tile(2, 1'b0, 0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
